// File: rtl/weight_stage_pkg.sv
// Shared types and width helpers for the weight staging buffer.
// Shadow bank state enum plus entry/lane width derivations.
package weight_stage_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } shadow_state_e;

   function automatic int entry_width(input int mdw, input int meta);
      return mdw + meta;
   endfunction

   function automatic int lane_width(input int alpha, input int beta,
                                     input int mdw, input int meta);
      return alpha * beta * entry_width(mdw, meta);
   endfunction

endpackage

// File: rtl/weight_stage_buffer_if.sv
// Load/commit/active-bank bundle between weight controller,
// staging buffer and PE array.
interface weight_stage_buffer_if #(
   parameter int K              = 16,
   parameter int M              = 16,
   parameter int ALPHA          = 4,
   parameter int BETA           = 2,
   parameter int MUL_DATAWIDTH  = 8,
   parameter int META_DATA_SIZE = 2
);
   import weight_stage_pkg::*;

   localparam int K_SCALED = K / BETA;
   localparam int M_SCALED = M / ALPHA;
   localparam int LANE_W   = lane_width(ALPHA, BETA, MUL_DATAWIDTH,
                                        META_DATA_SIZE);

   logic                                     weight_transferring_in;
   logic [M_SCALED-1:0][LANE_W-1:0]          weight_in;
   logic                                     weight_array_loaded;
   logic                                     commit;
   logic                                     load_ready;
   logic                                     shadow_full;
   logic                                     commit_ack;
   logic                                     active_valid;
   logic [K_SCALED-1:0][M_SCALED-1:0][LANE_W-1:0] weight_out;
   logic                                     tile_err;
   logic                                     meta_err;

   modport master (
      output weight_transferring_in, weight_in,
      output weight_array_loaded, commit,
      input  load_ready, shadow_full, commit_ack,
      input  active_valid, weight_out, tile_err, meta_err
   );

   modport slave (
      input  weight_transferring_in, weight_in,
      input  weight_array_loaded, commit,
      output load_ready, shadow_full, commit_ack,
      output active_valid, weight_out, tile_err, meta_err
   );

endinterface

// File: rtl/meta_group_checker.sv
// Flags a lane whose BETA-groups carry metadata that is neither
// all-zero (dense) nor strictly increasing. Purely combinational.
module meta_group_checker
   import weight_stage_pkg::*;
#(
   parameter int ALPHA          = 4,
   parameter int BETA           = 2,
   parameter int MUL_DATAWIDTH  = 8,
   parameter int META_DATA_SIZE = 2
) (
   input  logic [lane_width(ALPHA, BETA, MUL_DATAWIDTH,
                            META_DATA_SIZE)-1:0] lane_i,
   output logic                                  err_o
);

   localparam int EW  = entry_width(MUL_DATAWIDTH, META_DATA_SIZE);
   localparam int GW  = BETA * EW;

   function automatic logic group_bad(input logic [GW-1:0] grp);
      logic                      nz;
      logic                      inc;
      logic [META_DATA_SIZE-1:0] a;
      logic [META_DATA_SIZE-1:0] b;
      nz  = 1'b0;
      inc = 1'b1;
      for (int j = 0; j < BETA; j++) begin
         nz = nz | (|grp[j*EW+MUL_DATAWIDTH +: META_DATA_SIZE]);
      end
      for (int j = 1; j < BETA; j++) begin
         a = grp[(j-1)*EW+MUL_DATAWIDTH +: META_DATA_SIZE];
         b = grp[j*EW+MUL_DATAWIDTH +: META_DATA_SIZE];
         if (b <= a) inc = 1'b0;
      end
      return nz & ~inc;
   endfunction

   // OR together the per-group violations of this lane
   always_comb begin
      err_o = 1'b0;
      for (int g = 0; g < ALPHA; g++) begin
         err_o = err_o | group_bad(lane_i[g*GW +: GW]);
      end
   end

endmodule

// File: rtl/weight_stage_buffer.sv
// Double-buffered weight staging: shadow bank fills row by row,
// commit promotes it to the active bank. Metadata check: WEIGHT_META_CHECK_EN.
module weight_stage_buffer
   import weight_stage_pkg::*;
#(
   parameter int K              = 16,
   parameter int M              = 16,
   parameter int ALPHA          = 4,
   parameter int BETA           = 2,
   parameter int MUL_DATAWIDTH  = 8,
   parameter int META_DATA_SIZE = 2
) (
   input logic                  clk,
   input logic                  rst,
   weight_stage_buffer_if.slave bus
);

   localparam int K_SCALED = K / BETA;
   localparam int M_SCALED = M / ALPHA;
   localparam int LANE_W   = lane_width(ALPHA, BETA, MUL_DATAWIDTH,
                                        META_DATA_SIZE);
   localparam int RIW      = $clog2(K_SCALED) + 1;
   localparam int IW       = (K_SCALED > 1) ? $clog2(K_SCALED) : 1;

   typedef logic [K_SCALED-1:0][M_SCALED-1:0][LANE_W-1:0] bank_t;

   shadow_state_e  state_q, state_d;
   logic [RIW-1:0] row_idx_q, row_idx_d;
   bank_t          shadow_q, shadow_d;
   bank_t          active_q, active_d;
   logic           active_valid_q, active_valid_d;
   logic           ack_q, ack_d;
   logic           tile_err_q, tile_err_d;
   logic           capture;
   logic [RIW-1:0] cap_idx;

   // Shadow FSM, row capture, commit promotion and tile error tracking
   always_comb begin
      state_d        = state_q;
      row_idx_d      = row_idx_q;
      shadow_d       = shadow_q;
      active_d       = active_q;
      active_valid_d = active_valid_q;
      ack_d          = 1'b0;
      tile_err_d     = tile_err_q;
      capture        = 1'b0;
      cap_idx        = row_idx_q;
      case (state_q)
         EMPTY: begin
            cap_idx = RIW'(K_SCALED - 1);
            if (bus.weight_array_loaded) begin
               tile_err_d = 1'b1;
               shadow_d   = '0;
            end else if (bus.weight_transferring_in) begin
               capture = 1'b1;
            end
         end
         FILLING: begin
            if (bus.weight_array_loaded) begin
               tile_err_d = 1'b1;
               shadow_d   = '0;
               state_d    = EMPTY;
            end else if (bus.weight_transferring_in) begin
               capture = 1'b1;
            end
         end
         FULL: begin
            if (bus.commit) begin
               active_d       = shadow_q;
               active_valid_d = 1'b1;
               ack_d          = 1'b1;
               state_d        = EMPTY;
            end
            if (bus.weight_transferring_in) begin
               tile_err_d = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (capture) begin
         shadow_d[cap_idx[IW-1:0]] = bus.weight_in;
         if (cap_idx == '0) begin
            state_d = FULL;
         end else begin
            state_d   = FILLING;
            row_idx_d = cap_idx - RIW'(1);
         end
      end
   end

   // State and bank registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= EMPTY;
         row_idx_q      <= RIW'(K_SCALED - 1);
         shadow_q       <= '0;
         active_q       <= '0;
         active_valid_q <= 1'b0;
         ack_q          <= 1'b0;
         tile_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_idx_q      <= row_idx_d;
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         active_valid_q <= active_valid_d;
         ack_q          <= ack_d;
         tile_err_q     <= tile_err_d;
      end
   end

`ifdef WEIGHT_META_CHECK_EN
   logic [M_SCALED-1:0] lane_err;
   logic                meta_err_q;

   for (genvar g = 0; g < M_SCALED; g++) begin : g_chk
      meta_group_checker #(
         .ALPHA         (ALPHA),
         .BETA          (BETA),
         .MUL_DATAWIDTH (MUL_DATAWIDTH),
         .META_DATA_SIZE(META_DATA_SIZE)
      ) u_chk (
         .lane_i(bus.weight_in[g]),
         .err_o (lane_err[g])
      );
   end

   // Sticky metadata error, raised the cycle after a bad row is captured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) meta_err_q <= 1'b0;
      else     meta_err_q <= meta_err_q | (capture & (|lane_err));
   end

   assign bus.meta_err = meta_err_q;
`else
   assign bus.meta_err = 1'b0;
`endif

   assign bus.load_ready   = (state_q == EMPTY);
   assign bus.shadow_full  = (state_q == FULL);
   assign bus.commit_ack   = ack_q;
   assign bus.active_valid = active_valid_q;
   assign bus.weight_out   = active_q;
   assign bus.tile_err     = tile_err_q;

endmodule

// File: tb/tb_weight_stage_buffer.sv
// Directed bench for weight_stage_buffer at K=8, M=8, ALPHA=4, BETA=2.
// Covers load/commit, short tile, overrun, idle commit, reset, metadata.
module tb_weight_stage_buffer;

   localparam int K = 8, M = 8, ALPHA = 4, BETA = 2;
   localparam int MDW = 8, MDS = 2;
   localparam int EW = 10, LW = 80, KS = 4, MS = 2;
`ifdef WEIGHT_META_CHECK_EN
   localparam logic META_EN = 1'b1;
`else
   localparam logic META_EN = 1'b0;
`endif

   typedef logic [MS-1:0][LW-1:0] row_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   weight_stage_buffer_if #(
      .K(K), .M(M), .ALPHA(ALPHA), .BETA(BETA),
      .MUL_DATAWIDTH(MDW), .META_DATA_SIZE(MDS)
   ) bus ();

   weight_stage_buffer #(
      .K(K), .M(M), .ALPHA(ALPHA), .BETA(BETA),
      .MUL_DATAWIDTH(MDW), .META_DATA_SIZE(MDS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [LW-1:0] mk_lane(input logic [7:0] d,
                                             input logic [15:0] meta);
      logic [LW-1:0] l;
      l = '0;
      for (int e = 0; e < 8; e++) begin
         l[e*EW +: 8]     = d;
         l[e*EW + 8 +: 2] = meta[e*2 +: 2];
      end
      return l;
   endfunction

   function automatic row_t mk_row(input logic [7:0] d,
                                   input logic [15:0] meta);
      row_t r;
      r[0] = mk_lane(d, meta);
      r[1] = mk_lane(~d, 16'h0000);
      return r;
   endfunction

   task automatic push(input row_t r, input logic cm);
      @(negedge clk);
      bus.weight_in = r;
      bus.weight_transferring_in = 1'b1;
      bus.commit = cm;
      @(posedge clk);
      #1;
      bus.weight_transferring_in = 1'b0;
      bus.commit = 1'b0;
   endtask

   task automatic push_tile(input logic [7:0] base);
      for (int i = 0; i < KS; i++) begin
         push(mk_row(base + 8'(i), 16'h0), 1'b0);
      end
   endtask

   task automatic pulse_commit();
      @(negedge clk);
      bus.commit = 1'b1;
      @(posedge clk);
      #1;
      bus.commit = 1'b0;
   endtask

   task automatic pulse_loaded();
      @(negedge clk);
      bus.weight_array_loaded = 1'b1;
      @(posedge clk);
      #1;
      bus.weight_array_loaded = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.load_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_load_ready got %b want 1", bus.load_ready);
      end
      checks++;
      if ({bus.shadow_full, bus.commit_ack, bus.active_valid,
           bus.tile_err, bus.meta_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b%b%b%b%b want 00000",
                  bus.shadow_full, bus.commit_ack, bus.active_valid,
                  bus.tile_err, bus.meta_err);
      end
      checks++;
      if (bus.weight_out !== '0) begin
         errors++;
         $display("FAIL reset_weight_out got nonzero want 0");
      end
   endtask

   task automatic test_load_commit();
      push(mk_row(8'h11, 16'h0), 1'b0);
      checks++;
      if (bus.load_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_load_ready got %b want 0", bus.load_ready);
      end
      push(mk_row(8'h22, 16'h0), 1'b0);
      push(mk_row(8'h33, 16'h0), 1'b0);
      push(mk_row(8'h44, 16'h0), 1'b0);
      checks++;
      if (bus.shadow_full !== 1'b1) begin
         errors++;
         $display("FAIL shadow_full got %b want 1", bus.shadow_full);
      end
      pulse_commit();
      checks++;
      if ({bus.commit_ack, bus.active_valid, bus.load_ready} !== 3'b111) begin
         errors++;
         $display("FAIL commit_flags got %b%b%b want 111",
                  bus.commit_ack, bus.active_valid, bus.load_ready);
      end
      checks++;
      if (bus.weight_out[3][0] !== mk_lane(8'h11, 16'h0)) begin
         errors++;
         $display("FAIL wout_3_0 got %h want %h", bus.weight_out[3][0],
                  mk_lane(8'h11, 16'h0));
      end
      checks++;
      if (bus.weight_out[0][0] !== mk_lane(8'h44, 16'h0)) begin
         errors++;
         $display("FAIL wout_0_0 got %h want %h", bus.weight_out[0][0],
                  mk_lane(8'h44, 16'h0));
      end
      checks++;
      if (bus.weight_out[1][1] !== mk_lane(8'hCC, 16'h0)) begin
         errors++;
         $display("FAIL wout_1_1 got %h want %h", bus.weight_out[1][1],
                  mk_lane(8'hCC, 16'h0));
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.commit_ack !== 1'b0 || bus.tile_err !== 1'b0) begin
         errors++;
         $display("FAIL ack_pulse got ack=%b err=%b want 0 0",
                  bus.commit_ack, bus.tile_err);
      end
   endtask

   task automatic test_commit_empty();
      pulse_commit();
      checks++;
      if (bus.commit_ack !== 1'b0) begin
         errors++;
         $display("FAIL idle_commit_ack got %b want 0", bus.commit_ack);
      end
      checks++;
      if (bus.weight_out[2][0] !== mk_lane(8'h22, 16'h0)) begin
         errors++;
         $display("FAIL idle_commit_wout got %h want %h",
                  bus.weight_out[2][0], mk_lane(8'h22, 16'h0));
      end
   endtask

   task automatic test_overrun();
      push_tile(8'hA1);
      push(mk_row(8'hEE, 16'h0), 1'b1);
      checks++;
      if (bus.commit_ack !== 1'b1 || bus.tile_err !== 1'b1) begin
         errors++;
         $display("FAIL overrun_flags got ack=%b err=%b want 1 1",
                  bus.commit_ack, bus.tile_err);
      end
      checks++;
      if (bus.load_ready !== 1'b1 || bus.shadow_full !== 1'b0) begin
         errors++;
         $display("FAIL overrun_state got ready=%b full=%b want 1 0",
                  bus.load_ready, bus.shadow_full);
      end
      checks++;
      if (bus.weight_out[0][0] !== mk_lane(8'hA4, 16'h0)) begin
         errors++;
         $display("FAIL overrun_wout got %h want %h",
                  bus.weight_out[0][0], mk_lane(8'hA4, 16'h0));
      end
   endtask

   task automatic test_reset_mid_fill();
      push(mk_row(8'h51, 16'h0), 1'b0);
      push(mk_row(8'h52, 16'h0), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.load_ready, bus.shadow_full, bus.active_valid,
           bus.tile_err, bus.commit_ack} !== 5'b10000) begin
         errors++;
         $display("FAIL midrst_flags got %b%b%b%b%b want 10000",
                  bus.load_ready, bus.shadow_full, bus.active_valid,
                  bus.tile_err, bus.commit_ack);
      end
      checks++;
      if (bus.weight_out !== '0) begin
         errors++;
         $display("FAIL midrst_wout got nonzero want 0");
      end
      @(negedge clk);
      rst = 1'b0;
      push_tile(8'h61);
      checks++;
      if (bus.shadow_full !== 1'b1) begin
         errors++;
         $display("FAIL postrst_full got %b want 1", bus.shadow_full);
      end
      pulse_commit();
      checks++;
      if (bus.weight_out[3][0] !== mk_lane(8'h61, 16'h0) ||
          bus.weight_out[0][0] !== mk_lane(8'h64, 16'h0)) begin
         errors++;
         $display("FAIL postrst_wout got %h/%h want %h/%h",
                  bus.weight_out[3][0], bus.weight_out[0][0],
                  mk_lane(8'h61, 16'h0), mk_lane(8'h64, 16'h0));
      end
   endtask

   task automatic test_short_tile();
      push(mk_row(8'h71, 16'h0), 1'b0);
      push(mk_row(8'h72, 16'h0), 1'b0);
      pulse_loaded();
      checks++;
      if (bus.tile_err !== 1'b1 || bus.load_ready !== 1'b1) begin
         errors++;
         $display("FAIL short_flags got err=%b ready=%b want 1 1",
                  bus.tile_err, bus.load_ready);
      end
      checks++;
      if (bus.weight_out[3][0] !== mk_lane(8'h61, 16'h0)) begin
         errors++;
         $display("FAIL short_wout got %h want %h",
                  bus.weight_out[3][0], mk_lane(8'h61, 16'h0));
      end
      push_tile(8'h81);
      pulse_commit();
      checks++;
      if (bus.weight_out[2][0] !== mk_lane(8'h82, 16'h0) ||
          bus.weight_out[0][1] !== mk_lane(8'h7B, 16'h0)) begin
         errors++;
         $display("FAIL short_reload got %h/%h want %h/%h",
                  bus.weight_out[2][0], bus.weight_out[0][1],
                  mk_lane(8'h82, 16'h0), mk_lane(8'h7B, 16'h0));
      end
   endtask

   task automatic test_meta();
      push(mk_row(8'h91, 16'h00C0), 1'b0);
      checks++;
      if (bus.meta_err !== 1'b0) begin
         errors++;
         $display("FAIL meta_good got %b want 0", bus.meta_err);
      end
      push(mk_row(8'h92, 16'h0006), 1'b0);
      checks++;
      if (bus.meta_err !== META_EN) begin
         errors++;
         $display("FAIL meta_bad got %b want %b", bus.meta_err, META_EN);
      end
   endtask

   initial begin
      bus.weight_transferring_in = 1'b0;
      bus.weight_in = '0;
      bus.weight_array_loaded = 1'b0;
      bus.commit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_load_commit();
      test_commit_empty();
      test_overrun();
      test_reset_mid_fill();
      test_short_tile();
      test_meta();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
